// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake with fixed access latency.
// Optional macro MEM_RESP_ERR_EN enables out-of-range / misaligned address error responses.
module mem_responder #(
    parameter int          DEPTH     = 256,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            err_q, err_d;
    logic            resp_valid_q, resp_valid_d;
    logic [31:0]     resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;

    logic [31:0]     mem [DEPTH];
    logic [31:0]     off_s;
    logic            addr_err_s;
    logic            mem_wr_s;
    logic [31:0]     rd_word_s;

    assign off_s = req_addr - BASE_ADDR;

`ifdef MEM_RESP_ERR_EN
    // Range check on the unsigned offset also catches addresses below the base (wrap-around).
    logic unused_off_s;
    assign addr_err_s   = (off_s[31:AW+2] != {(30-AW){1'b0}}) || (req_addr[1:0] != 2'b00);
    assign unused_off_s = ^off_s[1:0];
`else
    logic unused_off_s;
    assign addr_err_s   = 1'b0;
    assign unused_off_s = ^{off_s[31:AW+2], off_s[1:0]};
`endif

    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    assign rd_word_s = mem[idx_q];
    assign mem_wr_s  = (state_q == WAIT) && (cnt_q == {CW{1'b0}}) && we_q && !err_q && !rst;

    // Next-state and output computation for the request/response FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        err_d        = err_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                resp_valid_d = 1'b0;
                if (req_valid) begin
                    we_d    = req_we;
                    idx_d   = off_s[AW+1:2];
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    err_d   = addr_err_s;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = err_q;
                    resp_rdata_d = (we_q || err_q) ? 32'h0000_0000 : rd_word_s;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // FSM and response registers; reset aborts any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= {CW{1'b0}};
            we_q         <= 1'b0;
            idx_q        <= {AW{1'b0}};
            wdata_q      <= 32'h0000_0000;
            wstrb_q      <= 4'h0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Storage array: byte-masked write on the edge entering RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder against a word-array reference model.
module tb_mem_responder;

    localparam int          DEPTH   = 256;
    localparam int          LATENCY = 2;
    localparam logic [31:0] BASE    = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_wstrb = 4'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] rdata; logic err; int acc; } exp_t;
    exp_t        sbq[$];
    logic [31:0] mdl [DEPTH];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rmode = 1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       resp_ready = ($urandom_range(0, 3) != 0);
            1:       resp_ready = 1'b1;
            default: resp_ready = 1'b0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: word index is the byte offset from BASE divided by 4, wrapped modulo DEPTH.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, output logic [31:0] rd, output logic err);
        longint off;
        logic [31:0] off32;
        int idx;
        off   = longint'(addr) - longint'(BASE);
        off32 = addr - BASE;
        idx   = int'((off32 / 4) % DEPTH);
`ifdef MEM_RESP_ERR_EN
        err = (off < 0) || (off >= 4 * DEPTH) || (addr % 4 != 0);
`else
        err = 1'b0;
        if (off == 0) idx = idx;
`endif
        rd = 32'h0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
            end else begin
                rd = mdl[idx];
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input bit abort, input bit keep, output int acc);
        int n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        acc = cyc + 1;
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL accept_timeout: got no req_ready expected accept within 200 cycles");
            req_valid = 1'b0;
        end else begin
            if (!abort) begin
                model(we, addr, wd, ws, e.rdata, e.err);
                e.acc = acc;
                sbq.push_back(e);
            end
            @(posedge clk);
            if (!keep) begin
                #1 req_valid = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: latency, stall stability, handshake data against the scoreboard queue.
    logic        prev_valid = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_rdata = 32'h0;
    logic        prev_err = 1'b0;
    exp_t        got;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            if (resp_valid) chk("req_ready_in_resp", {31'h0, req_ready}, 32'h0);
            if (prev_hold) begin
                chk("hold_valid", {31'h0, resp_valid}, 32'h1);
                chk("hold_rdata", resp_rdata, prev_rdata);
                chk("hold_err", {31'h0, resp_err}, {31'h0, prev_err});
            end
            if (resp_valid && !prev_valid) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
                end else begin
                    chk("latency", cyc - sbq[0].acc, LATENCY);
                end
            end
            if (resp_valid && resp_ready && sbq.size() != 0) begin
                got = sbq.pop_front();
                chk("rdata", resp_rdata, got.rdata);
                chk("err", {31'h0, resp_err}, {31'h0, got.err});
            end
            prev_valid = resp_valid;
            prev_hold  = resp_valid && !resp_ready;
            prev_rdata = resp_rdata;
            prev_err   = resp_err;
        end
    end

    initial begin
        #200000;
        total++; bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, dmy, n;
        logic [31:0] addr;
        #2;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);

        rmode = 1;
        for (int i = 0; i < DEPTH; i++)
            do_req(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 1'b0, 1'b0, dmy);
        drain();

        do_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, dmy);
        do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 1'b0, dmy);
        do_req(1'b1, 32'h8000_0010, 32'h0000_00AA, 4'h1, 1'b0, 1'b0, dmy);
        do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 1'b0, dmy);
        do_req(1'b0, 32'h8000_0400, 32'h0, 4'h0, 1'b0, 1'b0, dmy);
        drain();

        rmode = 2;
        do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 1'b0, dmy);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", {31'h0, resp_valid}, 32'h1);
            chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
        end
        rmode = 1;
        drain();
        chk("stall_return_idle", {31'h0, req_ready}, 32'h1);

        do_req(1'b0, 32'h8000_0020, 32'h0, 4'h0, 1'b0, 1'b1, a1);
        do_req(1'b0, 32'h8000_0024, 32'h0, 4'h0, 1'b0, 1'b0, a2);
        chk("b2b_spacing", a2 - a1, LATENCY + 2);
        drain();

        do_req(1'b1, 32'h8000_0020, 32'h1234_5678, 4'hF, 1'b1, 1'b0, dmy);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_req_ready", {31'h0, req_ready}, 32'h0);
        chk("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("abort_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        do_req(1'b0, 32'h8000_0020, 32'h0, 4'h0, 1'b0, 1'b0, dmy);
        drain();

        rmode = 0;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                7:       addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, DEPTH - 1));
                8:       addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
                9:       addr = BASE - 32'(4 * $urandom_range(1, 16));
                default: addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            endcase
            do_req(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
                   1'b0, 1'b0, dmy);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  DEPTH, 256, storage words; power of two, at least 4.
  LATENCY, 2, cycles from request accept to response valid; at least 1.
  BASE_ADDR, 32'h8000_0000, byte address of word 0.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  single clock; all state on rising edge.
  rst  in  1  asynchronous, active-high reset.
  req_valid  in  1  requester presents a request.
  req_ready  out  1  responder accepts a request this cycle.
  req_we  in  1  1 = write, 0 = read.
  req_addr  in  32  byte address.
  req_wdata  in  32  write data.
  req_wstrb  in  4  byte enables; bit i enables byte i.
  resp_valid  out  1  response present.
  resp_ready  in  1  requester takes the response.
  resp_rdata  out  32  read data; 0 for writes.
  resp_err  out  1  error response.

Function
REQ-003 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-004 req_ready SHALL be 1 only in IDLE with rst low, and 0 in WAIT, in RESP and while rst is high.
REQ-005 Accept SHALL be req_valid and req_ready at a rising edge; at accept, latch req_we, req_addr, req_wdata and req_wstrb, load the counter with LATENCY-1, and move to WAIT.
REQ-006 In WAIT, the counter SHALL decrement each cycle; on the edge where it is 0, move to RESP, so that resp_valid rises exactly LATENCY edges after accept.
REQ-007 The memory SHALL be read or written only on the edge entering RESP; read data SHALL be registered into resp_rdata on that edge.
REQ-008 For writes, only bytes with wstrb set SHALL change, and resp_rdata SHALL be 0.
REQ-009 The word index SHALL be the low log2(DEPTH) bits of (req_addr - BASE_ADDR) >> 2.
REQ-010 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_ready is 1 at an edge; then go to IDLE and clear resp_valid.
REQ-011 Minimum request spacing SHALL be LATENCY+2 cycles; a request held during WAIT or RESP is accepted on the first IDLE cycle.
REQ-012 resp_valid SHALL never be 1 in IDLE or WAIT.

Reset
REQ-013 rst high SHALL immediately force IDLE, with counter=0, resp_valid=0, resp_rdata=0, resp_err=0 and req_ready=0.
REQ-014 A request in WAIT when rst rises SHALL be aborted with no memory write and no response.
REQ-015 Storage contents SHALL NOT be reset; read-before-write data is undefined.

Configuration
REQ-016 With MEM_RESP_ERR_EN defined, an address outside [BASE_ADDR, BASE_ADDR+4*DEPTH) or with addr[1:0]!=0 SHALL give a response with resp_err=1 and resp_rdata=0, with no memory write and the same latency.
REQ-017 Without MEM_RESP_ERR_EN, resp_err SHALL be tied 0, addresses SHALL alias per REQ-009, and addr[1:0] SHALL be ignored.

Verification (DEPTH=256, LATENCY=2, BASE_ADDR=0x8000_0000)
REQ-018 Write 0xDEADBEEF to 0x8000_0010 with wstrb 1111, then read 0x8000_0010 -> resp_rdata=0xDEADBEEF, and resp_valid is high 2 edges after each accept.
REQ-019 Write 0x000000AA to 0x8000_0010 with wstrb 0001, then read -> 0xDEADBEAA.
REQ-020 Hold resp_ready=0 for 5 cycles during a read -> resp_valid, resp_rdata and resp_err stay constant and req_ready=0 throughout; the handshake then returns to IDLE.
REQ-021 Read 0x8000_0400 -> with MEM_RESP_ERR_EN: resp_err=1, resp_rdata=0; without it: returns the word at 0x8000_0000.
REQ-022 Assert rst for 1 cycle, one cycle after accepting a write of 0x12345678 to 0x8000_0020 -> no response is produced, and a later read of 0x8000_0020 returns the prior value.
REQ-023 Hold req_valid=1 with resp_ready=1 across two reads -> the second accept occurs on the edge after the first response handshake (a 4-cycle spacing).
